// File: rtl/retire_trace_fifo.sv
// Commit-trace FIFO placed after write-back: captures retired instructions
// and streams them out show-ahead over valid/ready, with counters and flags.
module retire_trace_fifo #(
  parameter int DEPTH      = 16,
  parameter int MAX_RETIRE = 200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       retire_valid,
  input  logic [31:0]                retire_pc,
  input  logic [31:0]                retire_instr,
  input  logic [4:0]                 retire_rd,
  input  logic [31:0]                retire_rd_val,
  input  logic [5:0]                 retire_type,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [31:0]                trace_pc,
  output logic [31:0]                trace_instr,
  output logic [31:0]                trace_rd_val,
  output logic [4:0]                 trace_rd,
  output logic [2:0]                 trace_type,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [31:0]                retire_count,
  output logic [15:0]                drop_count,
  output logic                       overflow,
  output logic                       illegal_type,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] rd_val;
    logic [2:0]  typ;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     retire_count_q, retire_count_d;
  logic [15:0]     drop_count_q, drop_count_d;
  logic            overflow_q, overflow_d;
  logic            illegal_q, illegal_d;
  logic            done_q, done_d;

  logic            cap;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;
  logic [2:0]      typ_enc;
  entry_t          wr_entry;
  entry_t          head_entry;

  always_comb begin
    typ_enc = 3'd7;
    case (retire_type)
      6'b000001: typ_enc = 3'd0;
      6'b000010: typ_enc = 3'd1;
      6'b000100: typ_enc = 3'd2;
      6'b001000: typ_enc = 3'd3;
      6'b010000: typ_enc = 3'd4;
      6'b100000: typ_enc = 3'd5;
      default:   typ_enc = 3'd7;
    endcase
  end

  always_comb begin
    wr_entry.pc     = retire_pc;
    wr_entry.instr  = retire_instr;
    wr_entry.rd     = retire_rd;
    // x0 reads as zero architecturally, so never trace a stale value.
    wr_entry.rd_val = (retire_rd == 5'd0) ? 32'd0 : retire_rd_val;
    wr_entry.typ    = typ_enc;
  end

  assign trace_valid = (count_q != '0);
  assign full        = (count_q == CW'(DEPTH));
  assign pop         = trace_valid && trace_ready;
  assign cap         = retire_valid && !done_q;
  assign push        = cap && (!full || pop);
  assign drop        = cap && !push;

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    retire_count_d = retire_count_q;
    drop_count_d   = drop_count_q;
    overflow_d     = overflow_q;
    illegal_d      = illegal_q;
    done_d         = done_q;
    if (pop) begin
      head_d = head_q + AW'(1);
    end
    if (push) begin
      tail_d = tail_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (cap) begin
      retire_count_d = retire_count_q + 32'd1;
      if (retire_count_d == 32'(MAX_RETIRE)) begin
        done_d = 1'b1;
      end
      if (typ_enc == 3'd7) begin
        illegal_d = 1'b1;
      end
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      retire_count_q <= '0;
      drop_count_q   <= '0;
      overflow_q     <= 1'b0;
      illegal_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      retire_count_q <= retire_count_d;
      drop_count_q   <= drop_count_d;
      overflow_q     <= overflow_d;
      illegal_q      <= illegal_d;
      done_q         <= done_d;
    end
  end

  // Storage is left unreset; the outputs are masked by trace_valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= wr_entry;
    end
  end

  assign head_entry   = mem_q[head_q];
  assign trace_pc     = trace_valid ? head_entry.pc     : 32'd0;
  assign trace_instr  = trace_valid ? head_entry.instr  : 32'd0;
  assign trace_rd     = trace_valid ? head_entry.rd     : 5'd0;
  assign trace_rd_val = trace_valid ? head_entry.rd_val : 32'd0;
  assign trace_type   = trace_valid ? head_entry.typ    : 3'd0;

  assign fifo_count   = count_q;
  assign retire_count = retire_count_q;
  assign drop_count   = drop_count_q;
  assign overflow     = overflow_q;
  assign illegal_type = illegal_q;
  assign done         = done_q;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Directed self-checking bench for retire_trace_fifo.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_retire_trace_fifo;

  localparam int DEPTH = 16;
  localparam int MAXR  = 200;

  logic        clk;
  logic        reset;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_instr;
  logic [4:0]  retire_rd;
  logic [31:0] retire_rd_val;
  logic [5:0]  retire_type;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic [31:0] trace_rd_val;
  logic [4:0]  trace_rd;
  logic [2:0]  trace_type;
  logic [4:0]  fifo_count;
  logic [31:0] retire_count;
  logic [15:0] drop_count;
  logic        overflow;
  logic        illegal_type;
  logic        done;

  int tests;
  int failed;

  retire_trace_fifo #(.DEPTH(DEPTH), .MAX_RETIRE(MAXR)) dut (
    .clk(clk), .reset(reset),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .retire_rd(retire_rd),
    .retire_rd_val(retire_rd_val), .retire_type(retire_type),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_instr(trace_instr),
    .trace_rd_val(trace_rd_val), .trace_rd(trace_rd),
    .trace_type(trace_type), .fifo_count(fifo_count),
    .retire_count(retire_count), .drop_count(drop_count),
    .overflow(overflow), .illegal_type(illegal_type), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ret(input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [4:0] rd,
                         input logic [31:0] val, input logic [5:0] typ);
    retire_valid  = v;
    retire_pc     = pc;
    retire_instr  = ins;
    retire_rd     = rd;
    retire_rd_val = val;
    retire_type   = typ;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_ret(1'b0, 0, 0, 0, 0, 6'b000001);
    trace_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (trace_valid !== 1'b0) begin failed++; $display("FAIL rst_valid got %b exp 0", trace_valid); end
    tests++; if (fifo_count !== 5'd0) begin failed++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
    tests++; if ({retire_count, drop_count} !== 48'd0) begin failed++; $display("FAIL rst_counters got %h exp 0", {retire_count, drop_count}); end
    tests++; if ({overflow, illegal_type, done} !== 3'b000) begin failed++; $display("FAIL rst_flags got %b exp 000", {overflow, illegal_type, done}); end
    tests++; if ({trace_pc, trace_instr, trace_rd_val, trace_rd, trace_type} !== 104'd0) begin failed++; $display("FAIL rst_trace got %h exp 0", {trace_pc, trace_instr, trace_rd_val, trace_rd, trace_type}); end
  endtask

  task automatic test_single();
    do_reset();
    trace_ready = 1'b1;
    set_ret(1'b1, 32'h2000, 32'h0050_0093, 5'd1, 32'd5, 6'b000010);
    @(negedge clk);
    set_ret(1'b0, 0, 0, 0, 0, 6'b000001);
    tests++; if (trace_valid !== 1'b1) begin failed++; $display("FAIL single_valid got %b exp 1", trace_valid); end
    tests++; if (trace_type !== 3'd1) begin failed++; $display("FAIL single_type got %0d exp 1", trace_type); end
    tests++; if (trace_pc !== 32'h2000 || trace_instr !== 32'h0050_0093) begin failed++; $display("FAIL single_pc_instr got %h %h exp 2000 00500093", trace_pc, trace_instr); end
    tests++; if (trace_rd !== 5'd1 || trace_rd_val !== 32'd5) begin failed++; $display("FAIL single_rd got %0d %0d exp 1 5", trace_rd, trace_rd_val); end
    tests++; if (fifo_count !== 5'd1) begin failed++; $display("FAIL single_count1 got %0d exp 1", fifo_count); end
    @(negedge clk);
    tests++; if (fifo_count !== 5'd0 || trace_valid !== 1'b0) begin failed++; $display("FAIL single_popped got %0d/%b exp 0/0", fifo_count, trace_valid); end
    tests++; if (retire_count !== 32'd1) begin failed++; $display("FAIL single_retcnt got %0d exp 1", retire_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      set_ret(1'b1, 32'h1000 + 32'(4 * i), 32'(i), 5'd3, 32'(i), 6'b000001);
      @(negedge clk);
    end
    set_ret(1'b0, 0, 0, 0, 0, 6'b000001);
    tests++; if (fifo_count !== 5'(DEPTH)) begin failed++; $display("FAIL ovf_count got %0d exp %0d", fifo_count, DEPTH); end
    tests++; if (drop_count !== 16'd3) begin failed++; $display("FAIL ovf_drops got %0d exp 3", drop_count); end
    tests++; if (overflow !== 1'b1) begin failed++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    tests++; if (retire_count !== 32'(DEPTH + 3)) begin failed++; $display("FAIL ovf_retcnt got %0d exp %0d", retire_count, DEPTH + 3); end
    trace_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tests++; if (trace_valid !== 1'b1 || trace_pc !== 32'h1000 + 32'(4 * i)) begin failed++; $display("FAIL ovf_drain%0d got %b/%h exp 1/%h", i, trace_valid, trace_pc, 32'h1000 + 32'(4 * i)); end
      @(negedge clk);
    end
    tests++; if (trace_valid !== 1'b0 || fifo_count !== 5'd0) begin failed++; $display("FAIL ovf_empty got %b/%0d exp 0/0", trace_valid, fifo_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_ret(1'b1, 32'h3000 + 32'(4 * i), 32'(i), 5'd2, 32'(i), 6'b000100);
      @(negedge clk);
    end
    trace_ready = 1'b1;
    set_ret(1'b1, 32'h3000 + 32'(4 * DEPTH), 0, 5'd2, 0, 6'b000100);
    @(negedge clk);
    tests++; if (fifo_count !== 5'(DEPTH)) begin failed++; $display("FAIL b2b_count got %0d exp %0d", fifo_count, DEPTH); end
    tests++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin failed++; $display("FAIL b2b_nodrop got %0d/%b exp 0/0", drop_count, overflow); end
    for (int j = DEPTH + 1; j < 3 * DEPTH; j++) begin
      tests++; if (trace_pc !== 32'h3000 + 32'(4 * (j - DEPTH))) begin failed++; $display("FAIL b2b_stream%0d got %h exp %h", j, trace_pc, 32'h3000 + 32'(4 * (j - DEPTH))); end
      set_ret(1'b1, 32'h3000 + 32'(4 * j), 0, 5'd2, 0, 6'b000100);
      @(negedge clk);
    end
    set_ret(1'b0, 0, 0, 0, 0, 6'b000001);
    tests++; if (fifo_count !== 5'(DEPTH) || drop_count !== 16'd0) begin failed++; $display("FAIL b2b_steady got %0d/%0d exp %0d/0", fifo_count, drop_count, DEPTH); end
    for (int k = 2 * DEPTH; k < 3 * DEPTH; k++) begin
      tests++; if (trace_valid !== 1'b1 || trace_pc !== 32'h3000 + 32'(4 * k)) begin failed++; $display("FAIL b2b_drain%0d got %b/%h exp 1/%h", k, trace_valid, trace_pc, 32'h3000 + 32'(4 * k)); end
      @(negedge clk);
    end
    tests++; if (trace_valid !== 1'b0 || retire_count !== 32'(3 * DEPTH)) begin failed++; $display("FAIL b2b_end got %b/%0d exp 0/%0d", trace_valid, retire_count, 3 * DEPTH); end
  endtask

  task automatic test_illegal();
    do_reset();
    trace_ready = 1'b0;
    set_ret(1'b1, 32'h4000, 32'h1, 5'd4, 32'h11, 6'b000000);
    @(negedge clk);
    tests++; if (illegal_type !== 1'b1) begin failed++; $display("FAIL ill_flag got %b exp 1", illegal_type); end
    set_ret(1'b1, 32'h4004, 32'h2, 5'd5, 32'h22, 6'b000101);
    @(negedge clk);
    set_ret(1'b1, 32'h4008, 32'h3, 5'd0, 32'hDEAD_BEEF, 6'b010000);
    @(negedge clk);
    set_ret(1'b0, 0, 0, 0, 0, 6'b000001);
    tests++; if (fifo_count !== 5'd3) begin failed++; $display("FAIL ill_count got %0d exp 3", fifo_count); end
    trace_ready = 1'b1;
    tests++; if (trace_type !== 3'd7 || trace_pc !== 32'h4000) begin failed++; $display("FAIL ill_zero got %0d/%h exp 7/4000", trace_type, trace_pc); end
    @(negedge clk);
    tests++; if (trace_type !== 3'd7 || trace_pc !== 32'h4004) begin failed++; $display("FAIL ill_multi got %0d/%h exp 7/4004", trace_type, trace_pc); end
    @(negedge clk);
    tests++; if (trace_type !== 3'd4 || trace_rd !== 5'd0) begin failed++; $display("FAIL x0_type got %0d/%0d exp 4/0", trace_type, trace_rd); end
    tests++; if (trace_rd_val !== 32'd0) begin failed++; $display("FAIL x0_val got %h exp 0", trace_rd_val); end
    @(negedge clk);
    tests++; if (illegal_type !== 1'b1 || trace_valid !== 1'b0) begin failed++; $display("FAIL ill_sticky got %b/%b exp 1/0", illegal_type, trace_valid); end
  endtask

  task automatic test_done();
    do_reset();
    trace_ready = 1'b1;
    for (int i = 0; i < MAXR - 1; i++) begin
      set_ret(1'b1, 32'h8000 + 32'(4 * i), 0, 5'd6, 0, 6'b001000);
      @(negedge clk);
    end
    tests++; if (done !== 1'b0 || retire_count !== 32'(MAXR - 1)) begin failed++; $display("FAIL done_early got %b/%0d exp 0/%0d", done, retire_count, MAXR - 1); end
    set_ret(1'b1, 32'h9000, 0, 5'd6, 0, 6'b001000);
    @(negedge clk);
    tests++; if (done !== 1'b1 || retire_count !== 32'(MAXR)) begin failed++; $display("FAIL done_rise got %b/%0d exp 1/%0d", done, retire_count, MAXR); end
    tests++; if (trace_valid !== 1'b1 || trace_pc !== 32'h9000) begin failed++; $display("FAIL done_last got %b/%h exp 1/9000", trace_valid, trace_pc); end
    set_ret(1'b0, 0, 0, 0, 0, 6'b000001);
    @(negedge clk);
    trace_ready = 1'b0;
    set_ret(1'b1, 32'hA000, 0, 5'd6, 0, 6'b000000);
    @(negedge clk);
    set_ret(1'b0, 0, 0, 0, 0, 6'b000001);
    tests++; if (retire_count !== 32'(MAXR) || fifo_count !== 5'd0) begin failed++; $display("FAIL done_ignore got %0d/%0d exp %0d/0", retire_count, fifo_count, MAXR); end
    tests++; if (drop_count !== 16'd0 || illegal_type !== 1'b0 || done !== 1'b1) begin failed++; $display("FAIL done_noside got %0d/%b/%b exp 0/0/1", drop_count, illegal_type, done); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ret(1'b1, 32'hB000 + 32'(4 * i), 0, 5'd7, 0, 6'b100000);
      @(negedge clk);
    end
    set_ret(1'b0, 0, 0, 0, 0, 6'b000001);
    tests++; if (fifo_count !== 5'd5 || trace_valid !== 1'b1) begin failed++; $display("FAIL mid_queued got %0d/%b exp 5/1", fifo_count, trace_valid); end
    #1 reset = 1'b0;
    #1;
    tests++; if (trace_valid !== 1'b0 || fifo_count !== 5'd0) begin failed++; $display("FAIL mid_async got %b/%0d exp 0/0", trace_valid, fifo_count); end
    tests++; if (retire_count !== 32'd0 || {overflow, illegal_type, done} !== 3'b000) begin failed++; $display("FAIL mid_counters got %0d/%b exp 0/000", retire_count, {overflow, illegal_type, done}); end
    #1 reset = 1'b1;
    @(negedge clk);
    tests++; if (trace_valid !== 1'b0 || fifo_count !== 5'd0) begin failed++; $display("FAIL mid_after got %b/%0d exp 0/0", trace_valid, fifo_count); end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    reset = 1'b0;
    trace_ready = 1'b0;
    set_ret(1'b0, 0, 0, 0, 0, 6'b000001);
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_illegal();
    test_done();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/retire_trace_fifo.md
# retire_trace_fifo

Synthesizable commit-trace buffer that sits directly downstream of the write-back stage of the RISC-V pipeline. Every retired instruction (pc, instr, rd, rd value, format) is captured into a show-ahead FIFO and streamed out over a valid/ready interface to the ISS comparator or host. The block counts retirements, flags drops and malformed format codes, and raises `done` after a fixed instruction budget, replacing the bench-side 200-instruction stop.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- MAX_RETIRE, 200, retirement budget; `done` fires when reached

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- retire_valid  in  1  one instruction retired this cycle (WB)
- retire_pc  in  32  PC of retired instruction
- retire_instr  in  32  instruction word
- retire_rd  in  5  destination register index
- retire_rd_val  in  32  register-file value of rd after write-back
- retire_type  in  6  one-hot format: bit0 R, bit1 I, bit2 S, bit3 B, bit4 U, bit5 J
- trace_valid  out  1  head entry available
- trace_ready  in  1  consumer accepts head entry
- trace_pc, trace_instr, trace_rd_val  out  32 each  head entry fields
- trace_rd  out  5  head entry rd
- trace_type  out  3  encoded format: R=0, I=1, S=2, B=3, U=4, J=5, 7=illegal
- fifo_count  out  $clog2(DEPTH)+1  occupied entries
- retire_count  out  32  retirements counted (accepted + dropped)
- drop_count  out  16  retirements lost to full FIFO, saturating
- overflow  out  1  sticky: at least one drop
- illegal_type  out  1  sticky: retire_type not exactly one-hot
- done  out  1  sticky: retire_count reached MAX_RETIRE

## Operation
- Entry = {pc, instr, rd, rd_val, type}, 104 bits; storage is a register array with head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH.
- Capture: when retire_valid && !done, the event is counted (retire_count+1) and written if `fifo_count < DEPTH`, or `fifo_count == DEPTH` and a pop occurs the same cycle. Otherwise dropped: drop_count+1 (saturate at 16'hFFFF), overflow set.
- rd == 0: stored rd_val forced to 0 regardless of input.
- Type encode: exactly one bit set → index of that bit; zero or multiple bits → 7 and illegal_type set. Entry still captured.
- Pop: trace_valid && trace_ready. trace_valid = (fifo_count != 0); trace_* driven from head entry (show-ahead). trace_* are don't-care while trace_valid is 0.
- Simultaneous push and pop: fifo_count unchanged; both pointers advance.
- done: set on the edge where retire_count becomes MAX_RETIRE. Afterwards retire_valid is ignored entirely (no write, no count, no drop). FIFO continues to drain normally.
- trace_ready while empty: no effect.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): pointers 0, fifo_count 0, trace_valid 0, retire_count 0, drop_count 0, overflow 0, illegal_type 0, done 0; trace_pc/instr/rd_val 0, trace_rd 0, trace_type 0. Array contents not reset.
- Reset mid-operation: all queued entries discarded immediately; no trace_valid in the cycle after release.
- Write latency: retire at edge N → entry visible on trace_* with trace_valid=1 in cycle after edge N (1 cycle), if FIFO was empty.
- Pop at edge N → next entry (or trace_valid=0) after edge N.
- Sticky flags and done update on the same edge as the causing event.
- Full throughput: one push and one pop per cycle sustained.

## Test plan
- Single retire pc=0x2000, instr=0x00500093, rd=1, rd_val=5, type=6'b000010 with trace_ready=1 → one cycle later trace_valid=1, trace_type=1, fields match; popped next edge, fifo_count back to 0, retire_count=1.
- Hold trace_ready=0, retire DEPTH+3 back-to-back → fifo_count=DEPTH, drop_count=3, overflow=1, retire_count=DEPTH+3; draining yields first DEPTH entries in order with pc values intact.
- FIFO full, retire and trace_ready=1 same cycle → entry accepted, drop_count unchanged, fifo_count stays DEPTH; pointer wrap verified over 3×DEPTH entries.
- retire_type=6'b000000 then 6'b000101 → both entries trace_type=7, illegal_type=1; retire with rd=0, rd_val=0xDEADBEEF → trace_rd_val=0.
- 200 retires with MAX_RETIRE=200 → done rises on 200th edge; 201st retire ignored (retire_count=200, no new entry).
- Assert reset low with 5 entries queued → trace_valid=0 and all counters/flags 0 asynchronously, before next clock edge.
